// File: rtl/nv_nvdla_sdp_hls_y_int_alu.sv
// SDP Y-path integer ALU: two-stage MAX/MIN/SUM/EQL/bypass pipeline
// with a valid/ready join against the streamed operand.
module nv_nvdla_sdp_hls_y_int_alu #(
  parameter int SAT_EN = 1
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        cfg_alu_bypass,
  input  logic [1:0]  cfg_alu_algo,
  input  logic        cfg_alu_src,
  input  logic [31:0] cfg_alu_op,
  input  logic [31:0] alu_data_in,
  input  logic        alu_in_pvld,
  output logic        alu_in_prdy,
  input  logic [31:0] chn_op_in,
  input  logic        chn_op_pvld,
  output logic        chn_op_prdy,
  output logic [31:0] alu_data_out,
  output logic        alu_out_pvld,
  input  logic        alu_out_prdy
);

  localparam logic [1:0] ALGO_MAX = 2'd0;
  localparam logic [1:0] ALGO_MIN = 2'd1;
  localparam logic [1:0] ALGO_SUM = 2'd2;
  localparam logic [1:0] ALGO_EQL = 2'd3;

  logic        r_s1_vld;
  logic [32:0] r_s1_raw;
  logic [1:0]  r_s1_algo;
  logic        r_s1_byp;
  logic        r_s2_vld;
  logic [31:0] r_s2_data;

  logic        w_need_op;
  logic        w_s2_rdy;
  logic        w_s1_rdy;
  logic        w_accept;
  logic [31:0] w_b;
  logic [32:0] w_sa;
  logic [32:0] w_sb;
  logic [32:0] w_sum;
  logic        w_ge;
  logic        w_le;
  logic        w_eq;
  logic [32:0] w_raw;
  logic [31:0] w_s1_res;

  assign w_need_op = !cfg_alu_bypass && !cfg_alu_src;
  assign w_s2_rdy  = !r_s2_vld || alu_out_prdy;
  assign w_s1_rdy  = !r_s1_vld || w_s2_rdy;

  // Each ready sees only the other stream's valid, never its own.
  assign alu_in_prdy = w_need_op ? (w_s1_rdy && chn_op_pvld) : w_s1_rdy;
  assign chn_op_prdy = w_need_op ? (w_s1_rdy && alu_in_pvld) : 1'b0;
  assign w_accept    = alu_in_pvld && alu_in_prdy;

  assign w_b   = cfg_alu_src ? cfg_alu_op : chn_op_in;
  assign w_sa  = {alu_data_in[31], alu_data_in};
  assign w_sb  = {w_b[31], w_b};
  assign w_sum = w_sa + w_sb;
  assign w_ge  = $signed(alu_data_in) >= $signed(w_b);
  assign w_le  = $signed(alu_data_in) <= $signed(w_b);
  assign w_eq  = alu_data_in == w_b;

  always_comb begin
    w_raw = w_sa;
    if (!cfg_alu_bypass) begin
      unique case (cfg_alu_algo)
        ALGO_MAX: w_raw = w_ge ? w_sa : w_sb;
        ALGO_MIN: w_raw = w_le ? w_sa : w_sb;
        ALGO_SUM: w_raw = w_sum;
        ALGO_EQL: w_raw = {32'd0, w_eq};
        default:  w_raw = w_sa;
      endcase
    end
  end

  // Only a SUM can leave the 32-bit range; bits 32/31 disagree on overflow.
  always_comb begin
    w_s1_res = r_s1_raw[31:0];
    if (SAT_EN != 0 && !r_s1_byp && r_s1_algo == ALGO_SUM
        && (r_s1_raw[32] != r_s1_raw[31])) begin
      w_s1_res = r_s1_raw[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_raw  <= '0;
      r_s1_algo <= '0;
      r_s1_byp  <= 1'b0;
    end else if (w_s1_rdy) begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_raw  <= w_raw;
        r_s1_algo <= cfg_alu_algo;
        r_s1_byp  <= cfg_alu_bypass;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
    end else if (w_s2_rdy) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_s1_res;
      end
    end
  end

  assign alu_data_out = r_s2_data;
  assign alu_out_pvld = r_s2_vld;

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_y_int_alu.sv
// Directed bench for the SDP Y int ALU: ops, saturation, join,
// back-pressure, in-flight config and mid-flight reset.
module tb_nv_nvdla_sdp_hls_y_int_alu;

  logic        clk;
  logic        rst;
  logic        byp;
  logic [1:0]  algo;
  logic        src;
  logic [31:0] op;
  logic [31:0] din;
  logic        in_pvld;
  logic        in_prdy;
  logic [31:0] cin;
  logic        c_pvld;
  logic        c_prdy;
  logic [31:0] dout;
  logic        out_pvld;
  logic        out_prdy;

  int checks;
  int failures;

  nv_nvdla_sdp_hls_y_int_alu #(.SAT_EN(1)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_alu_bypass (byp),
    .cfg_alu_algo   (algo),
    .cfg_alu_src    (src),
    .cfg_alu_op     (op),
    .alu_data_in    (din),
    .alu_in_pvld    (in_pvld),
    .alu_in_prdy    (in_prdy),
    .chn_op_in      (cin),
    .chn_op_pvld    (c_pvld),
    .chn_op_prdy    (c_prdy),
    .alu_data_out   (dout),
    .alu_out_pvld   (out_pvld),
    .alu_out_prdy   (out_prdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One beat through an idle pipe, output checked two edges after launch.
  task automatic run1(input string tag, input logic [1:0] a_algo,
                      input logic a_src, input logic a_byp,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    algo = a_algo;
    src = a_src;
    byp = a_byp;
    op = b;
    cin = b;
    din = a;
    in_pvld = 1'b1;
    c_pvld = 1'b1;
    tick();
    in_pvld = 1'b0;
    c_pvld = 1'b0;
    chk({tag, "_lat1"}, 32'(out_pvld), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(out_pvld), 32'd1);
    chk({tag, "_data"}, dout, exp);
    tick();
    chk({tag, "_drain"}, 32'(out_pvld), 32'd0);
  endtask

  logic m1;
  logic m2;
  logic acc;
  logic drn;
  logic s1r;
  logic s2r;
  int   sent;
  int   rcv;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    byp = 1'b0;
    algo = 2'd0;
    src = 1'b1;
    op = '0;
    din = '0;
    in_pvld = 1'b0;
    cin = '0;
    c_pvld = 1'b0;
    out_prdy = 1'b1;

    tick();
    tick();
    chk("rst_vld", 32'(out_pvld), 32'd0);
    chk("rst_data", dout, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_inrdy_src1", 32'(in_prdy), 32'd1);
    chk("rst_crdy_src1", 32'(c_prdy), 32'd0);
    src = 1'b0;
    #1;
    chk("rst_crdy_src0", 32'(c_prdy), 32'd0);
    chk("rst_inrdy_src0", 32'(in_prdy), 32'd0);
    tick();

    run1("sum_satp", 2'd2, 1'b0, 1'b0, 32'h7FFF_FFF0, 32'h20, 32'h7FFF_FFFF);
    run1("sum_satn", 2'd2, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
         32'h8000_0000);
    run1("sum_plain", 2'd2, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFD, 32'd2);
    run1("max", 2'd0, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd3, 32'd3);
    run1("min", 2'd1, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFB);
    run1("eql_t", 2'd3, 1'b0, 1'b0, 32'd7, 32'd7, 32'd1);
    run1("eql_f", 2'd3, 1'b0, 1'b0, 32'd7, 32'd8, 32'd0);
    run1("sum_reg", 2'd2, 1'b1, 1'b0, 32'hFFFF_FFCE, 32'd100, 32'd50);
    run1("bypass", 2'd2, 1'b0, 1'b1, 32'h1234_5678, 32'h7FFF_FFFF,
         32'h1234_5678);

    // Join: data valid alone must not be consumed.
    algo = 2'd2;
    src = 1'b0;
    byp = 1'b0;
    din = 32'd10;
    cin = 32'd20;
    in_pvld = 1'b1;
    c_pvld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("join_inrdy", 32'(in_prdy), 32'd0);
      chk("join_crdy", 32'(c_prdy), 32'd1);
      tick();
      chk("join_novld", 32'(out_pvld), 32'd0);
    end
    c_pvld = 1'b1;
    #1;
    chk("join_go", 32'(in_prdy), 32'd1);
    tick();
    in_pvld = 1'b0;
    c_pvld = 1'b0;
    tick();
    chk("join_vld", 32'(out_pvld), 32'd1);
    chk("join_data", dout, 32'd30);
    tick();
    chk("join_once", 32'(out_pvld), 32'd0);

    // Back-pressure: 8 beats, out_prdy pattern 1,0,0 repeating.
    algo = 2'd2;
    src = 1'b1;
    byp = 1'b0;
    op = 32'd1;
    m1 = 1'b0;
    m2 = 1'b0;
    sent = 0;
    rcv = 0;
    for (int c = 0; c < 100 && rcv < 8; c++) begin
      out_prdy = (c % 3 == 0);
      in_pvld = (sent < 8);
      din = 32'(sent * 3);
      #1;
      chk("bp_inrdy", 32'(in_prdy), 32'(!m1 || !m2 || out_prdy));
      chk("bp_vld", 32'(out_pvld), 32'(m2));
      acc = in_pvld && in_prdy;
      drn = out_pvld && out_prdy;
      if (drn) begin
        chk("bp_data", dout, 32'(rcv * 3 + 1));
        rcv++;
      end
      tick();
      s2r = !m2 || out_prdy;
      s1r = !m1 || s2r;
      if (s2r) m2 = m1;
      if (s1r) m1 = acc;
      if (acc) sent++;
    end
    in_pvld = 1'b0;
    out_prdy = 1'b1;
    chk("bp_count", 32'(rcv), 32'd8);
    tick();
    chk("bp_empty", 32'(out_pvld), 32'd0);

    // Bypass ignores the stream; config change must not touch beats in flight.
    byp = 1'b1;
    src = 1'b0;
    algo = 2'd2;
    din = 32'h11;
    cin = 32'h1000;
    in_pvld = 1'b1;
    c_pvld = 1'b1;
    #1;
    chk("byp_crdy", 32'(c_prdy), 32'd0);
    tick();
    byp = 1'b0;
    src = 1'b1;
    algo = 2'd0;
    op = 32'd50;
    tick();
    in_pvld = 1'b0;
    c_pvld = 1'b0;
    algo = 2'd1;
    chk("cfg_b0_data", dout, 32'h11);
    chk("cfg_b0_vld", 32'(out_pvld), 32'd1);
    tick();
    chk("cfg_b1_data", dout, 32'd50);
    chk("cfg_b1_vld", 32'(out_pvld), 32'd1);
    tick();

    // Reset with two beats held in the pipe.
    out_prdy = 1'b0;
    algo = 2'd2;
    src = 1'b1;
    op = 32'd1;
    din = 32'd40;
    in_pvld = 1'b1;
    tick();
    din = 32'd41;
    tick();
    in_pvld = 1'b0;
    chk("rstm_full", 32'(out_pvld), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstm_vld", 32'(out_pvld), 32'd0);
    chk("rstm_data", dout, 32'd0);
    rst = 1'b0;
    out_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstm_gone", 32'(out_pvld), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
